// File: rtl/celda_pkg.sv
// Shared constants for the serializer that feeds the initial parity cell.
// Holds the FSM encoding, the seed width and the result latency.
package celda_pkg;

  localparam int SEED_W  = 3;
  // Cycles from the last serial bit to the res_valid pulse.
  localparam int RES_LAT = 2;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/registro_desplazamiento.sv
// Parallel-load shift register. Its head bit is the serial output. Zeros are
// shifted in, so after W shifts the output rests at 0 until the next load.
module registro_desplazamiento #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         ser_o
);

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[W-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign ser_o = MSB_FIRST ? sreg_q[W-1] : sreg_q[0];

endmodule

// File: rtl/serializador_celda.sv
// Feeds one word per W+2 cycles bit-serially into the initial parity cell and
// returns the cell's parity output as a one-cycle result pulse.
module serializador_celda
  import celda_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      in_data,
  input  logic [SEED_W-1:0] in_seed,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              l_out,
  output logic              seed_x,
  output logic              seed_y,
  output logic              seed_z,
  output logic              bit_valid,
  output logic              first_bit,
  output logic              last_bit,
  input  logic              ip_in,
  output logic              res_valid,
  output logic              res_bit,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a word moves when in_valid and in_ready are both high at a
  // rising edge; in_valid while busy is ignored and nothing is captured.

  localparam int CW = $clog2(W);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic                bit_valid_q, bit_valid_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                res_valid_q, res_valid_d;
  logic                res_bit_q, res_bit_d;
  logic                accept;
  logic                load;
  logic                shift;

  assign in_ready = (state_q == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    bit_valid_d = bit_valid_q;
    first_d     = 1'b0;
    last_d      = 1'b0;
    res_valid_d = 1'b0;
    res_bit_d   = res_bit_q;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SHIFT;
          cnt_d       = CW'(W - 1);
          seed_d      = in_seed;
          bit_valid_d = 1'b1;
          first_d     = 1'b1;
          load        = 1'b1;
        end
      end
      ST_SHIFT: begin
        // The final shift empties the register so l_out drops to 0 in WAIT.
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d     = ST_WAIT;
          bit_valid_d = 1'b0;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          last_d = (cnt_q == CW'(1));
        end
      end
      ST_WAIT: begin
        res_valid_d = 1'b1;
        res_bit_d   = ip_in;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        bit_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seed_q      <= '0;
      bit_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      bit_valid_q <= bit_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
    end
  end

  registro_desplazamiento #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (in_data),
    .ser_o   (l_out)
  );

  assign seed_x    = seed_q[2];
  assign seed_y    = seed_q[1];
  assign seed_z    = seed_q[0];
  assign bit_valid = bit_valid_q;
  assign first_bit = first_q;
  assign last_bit  = last_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serializador_celda.sv
// Bench for serializador_celda: two instances (MSB-first and LSB-first) share
// one stimulus stream; a cell stub drives ip_in on each.
module tb_serializador_celda;
  import celda_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic        first;
    logic        last;
    logic        b;
    logic [31:0] cyc;
  } bit_ent_t;

  typedef struct packed {
    logic        b;
    logic [31:0] cyc;
  } res_ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic [2:0]   in_seed = '0;
  logic         in_valid = 1'b0;

  logic [1:0] rdy, l, sx, sy, sz, bv, fb, lb, rv, rb, bsy, ip;
  logic [1:0] st_a, st_b;
  logic [1:0] cell_p;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit_ent_t exp_bits_a[$];
  bit_ent_t exp_bits_b[$];
  res_ent_t exp_res_a[$];
  res_ent_t exp_res_b[$];
  int         busy_lo = 1;
  int         busy_hi = 0;
  logic [2:0] cur_seed = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  serializador_celda #(.W(W), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_seed(in_seed),
    .in_valid(in_valid), .in_ready(rdy[0]), .l_out(l[0]),
    .seed_x(sx[0]), .seed_y(sy[0]), .seed_z(sz[0]),
    .bit_valid(bv[0]), .first_bit(fb[0]), .last_bit(lb[0]),
    .ip_in(ip[0]), .res_valid(rv[0]), .res_bit(rb[0]),
    .busy(bsy[0]), .state_dbg(st_a)
  );

  serializador_celda #(.W(W), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_seed(in_seed),
    .in_valid(in_valid), .in_ready(rdy[1]), .l_out(l[1]),
    .seed_x(sx[1]), .seed_y(sy[1]), .seed_z(sz[1]),
    .bit_valid(bv[1]), .first_bit(fb[1]), .last_bit(lb[1]),
    .ip_in(ip[1]), .res_valid(rv[1]), .res_bit(rb[1]),
    .busy(bsy[1]), .state_dbg(st_b)
  );

  // Cell stub: registered running parity, seeded with x^y^z on the first bit.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) cell_p[k] <= 1'b0;
      else if (bv[k] && fb[k]) cell_p[k] <= sx[k] ^ sy[k] ^ sz[k] ^ l[k];
      else if (bv[k]) cell_p[k] <= cell_p[k] ^ l[k];
    end
  end
  assign ip = cell_p;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: bit i of a word goes out in cycle acc+1+i; the result is the
  // parity of seed and word, RES_LAT cycles after the last bit.
  task automatic push_expected(input logic [W-1:0] d, input logic [2:0] s, input int acc);
    bit_ent_t ea, eb;
    res_ent_t r;
    for (int i = 0; i < W; i++) begin
      ea.first = (i == 0);
      ea.last  = (i == W - 1);
      ea.cyc   = 32'(acc + 1 + i);
      eb       = ea;
      ea.b     = d[W-1-i];
      eb.b     = d[i];
      exp_bits_a.push_back(ea);
      exp_bits_b.push_back(eb);
    end
    r.b   = ($countones(d) + $countones(s)) % 2 == 1;
    r.cyc = 32'(acc + W + RES_LAT);
    exp_res_a.push_back(r);
    exp_res_b.push_back(r);
    busy_lo = acc + 1;
    busy_hi = acc + W + 1;
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [W-1:0] d, input logic [2:0] s, input bit keep,
                      output int acc, output logic rv_acc);
    bit done = 1'b0;
    acc = -1;
    rv_acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_seed  = s;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (rdy[0] && !rst) begin
        acc = cyc;
        rv_acc = rv[0];
        push_expected(d, s, cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (done) cur_seed = s;
    else flag_fail("send_timeout: word never accepted");
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_bits_a.delete();
    exp_bits_b.delete();
    exp_res_a.delete();
    exp_res_b.delete();
    busy_lo = 1;
    busy_hi = 0;
    cur_seed = '0;
    idle(n);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_outputs[%0d]", k),
          32'({l[k], sx[k], sy[k], sz[k], bv[k], fb[k], lb[k], rv[k], rb[k], bsy[k]}), 32'd0);
      chk($sformatf("rst_in_ready_low[%0d]", k), 32'(rdy[k]), 32'd0);
    end
    chk("rst_state_a", 32'(st_a), 32'(ST_IDLE));
    chk("rst_state_b", 32'(st_b), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready_a", 32'(rdy[0]), 32'd1);
    chk("rst_release_ready_b", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        bit       exp_busy;
        bit       have;
        bit_ent_t e;
        res_ent_t r;
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(exp_busy));
        chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(!exp_busy));
        chk($sformatf("seed_xyz[%0d]", k), 32'({sx[k], sy[k], sz[k]}), 32'(cur_seed));

        if (k == 0) begin
          while (exp_bits_a.size() > 0 && int'(exp_bits_a[0].cyc) < cyc) begin
            void'(exp_bits_a.pop_front());
            flag_fail("missed_bit[0]");
          end
          while (exp_res_a.size() > 0 && int'(exp_res_a[0].cyc) < cyc) begin
            void'(exp_res_a.pop_front());
            flag_fail("missed_result[0]");
          end
        end else begin
          while (exp_bits_b.size() > 0 && int'(exp_bits_b[0].cyc) < cyc) begin
            void'(exp_bits_b.pop_front());
            flag_fail("missed_bit[1]");
          end
          while (exp_res_b.size() > 0 && int'(exp_res_b[0].cyc) < cyc) begin
            void'(exp_res_b.pop_front());
            flag_fail("missed_result[1]");
          end
        end

        if (bv[k]) begin
          have = 1'b0;
          if (k == 0 && exp_bits_a.size() > 0) begin e = exp_bits_a.pop_front(); have = 1'b1; end
          if (k == 1 && exp_bits_b.size() > 0) begin e = exp_bits_b.pop_front(); have = 1'b1; end
          if (!have) flag_fail($sformatf("unexpected_bit[%0d]", k));
          else begin
            chk($sformatf("bit_first_last_l[%0d]", k), 32'({fb[k], lb[k], l[k]}),
                32'({e.first, e.last, e.b}));
            chk($sformatf("bit_cycle[%0d]", k), 32'(cyc), e.cyc);
          end
        end else begin
          chk($sformatf("idle_l_first_last[%0d]", k), 32'({l[k], fb[k], lb[k]}), 32'd0);
        end

        if (rv[k]) begin
          have = 1'b0;
          if (k == 0 && exp_res_a.size() > 0) begin r = exp_res_a.pop_front(); have = 1'b1; end
          if (k == 1 && exp_res_b.size() > 0) begin r = exp_res_b.pop_front(); have = 1'b1; end
          if (!have) flag_fail($sformatf("unexpected_res_valid[%0d]", k));
          else begin
            chk($sformatf("res_bit[%0d]", k), 32'(rb[k]), 32'(r.b));
            chk($sformatf("res_cycle[%0d]", k), 32'(cyc), r.cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   acc1, acc2, acc;
    logic rva;
    logic [W-1:0] d;
    logic [2:0]   s;

    do_reset(3);

    // Reference pattern, both bit orders.
    send(8'hB2, 3'b000, 1'b0, acc, rva);
    idle(W + 3);

    // Seed routing and hold through IDLE.
    send(8'h3C, 3'b101, 1'b0, acc, rva);
    idle(W + 6);

    // Back-to-back with in_valid held high.
    send(8'hFF, 3'b011, 1'b1, acc1, rva);
    send(8'h01, 3'b110, 1'b0, acc2, rva);
    chk("b2b_spacing", 32'(acc2 - acc1), 32'(W + 2));
    chk("b2b_accept_on_res_valid", 32'(rva), 32'd1);
    idle(W + 3);

    // Offer a word while busy; it must be dropped.
    send(8'hA7, 3'b010, 1'b0, acc, rva);
    idle(3);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_seed  = 3'b111;
    @(negedge clk);
    chk("busy_drop_in_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(W + 3);

    // Reset in the middle of SHIFT aborts the word.
    send(8'hC3, 3'b110, 1'b0, acc, rva);
    idle(3);
    do_reset(3);
    idle(W + 4);
    send(8'h5A, 3'b001, 1'b0, acc, rva);
    idle(W + 3);

    // Randomized traffic, with optional back-to-back chaining.
    for (int i = 0; i < 24; i++) begin
      d = W'($urandom);
      s = 3'($urandom_range(0, 7));
      send(d, s, ($urandom_range(0, 2) == 0), acc, rva);
      if (!in_valid) idle($urandom_range(0, W + 3));
    end
    in_valid = 1'b0;
    idle(W + 6);

    chk("drain_bits_a", 32'(exp_bits_a.size()), 32'd0);
    chk("drain_bits_b", 32'(exp_bits_b.size()), 32'd0);
    chk("drain_res_a", 32'(exp_res_a.size()), 32'd0);
    chk("drain_res_b", 32'(exp_res_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
